// File: rtl/cfg_ff_bank.sv
// -----------------------------------------------------------------------------
// cfg_ff_bank
// A bank of WIDTH flip-flops whose element type (D, T, JK, SR) is selected
// every enabled cycle by 'mode'. The bank also keeps a saturating count of
// cycles in which its state changed, and a sticky flag for illegal S=R=1 in
// SR mode.
//
// Ports
//   clk      in   1      rising-edge clock for all state
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      update enable; 0 holds q, chg_cnt and sr_err
//   mode     in   2      00 D, 01 T, 10 JK, 11 SR (applies to all bits)
//   a        in   WIDTH  D / T / J / S per bit
//   b        in   WIDTH  K (JK) or R (SR) per bit, ignored in D and T
//   clr_cnt  in   1      synchronous clear of chg_cnt and sr_err
//   q        out  WIDTH  registered bank state
//   q_bar    out  WIDTH  bitwise inverse of q
//   chg_cnt  out  CNT_W  saturating count of cycles in which q changed
//   sr_err   out  1      sticky illegal-SR flag
// -----------------------------------------------------------------------------
module cfg_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Characteristic equations of the four element types, applied bitwise.
    // In SR mode an S=R=1 bit keeps its old value (the error is flagged
    // separately).
    function automatic logic [WIDTH-1:0] next_state(
        input logic [1:0]       md,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] da,
        input logic [WIDTH-1:0] db
    );
        logic [WIDTH-1:0] nxt;
        case (md)
            2'b00:   nxt = da;
            2'b01:   nxt = cur ^ da;
            2'b10:   nxt = (da & ~cur) | (~db & cur);
            2'b11:   nxt = (da & ~db) | (cur & ~(db & ~da));
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    logic [WIDTH-1:0] q_next_s;
    logic             changed_s;
    logic             sr_ill_s;
    logic             cnt_sat_s;

    // Next-state decode and change / illegal-SR / saturation detection.
    always_comb begin
        q_next_s  = next_state(mode, q_r, a, b);
        changed_s = (q_next_s != q_r);
        cnt_sat_s = &cnt_r;
        if (mode == 2'b11) begin
            sr_ill_s = |(a & b);
        end else begin
            sr_ill_s = 1'b0;
        end
    end

    // Bank state register: loads the decoded next state on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (en) begin
            q_r <= q_next_s;
        end else begin
            q_r <= q_r;
        end
    end

    // Change counter and sticky error; clr_cnt overrides same-cycle events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            err_r <= 1'b0;
        end else if (clr_cnt) begin
            cnt_r <= {CNT_W{1'b0}};
            err_r <= 1'b0;
        end else if (en) begin
            if (changed_s && !cnt_sat_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            err_r <= err_r | sr_ill_s;
        end else begin
            cnt_r <= cnt_r;
            err_r <= err_r;
        end
    end

    assign q       = q_r;
    assign q_bar   = ~q_r;
    assign chg_cnt = cnt_r;
    assign sr_err  = err_r;

endmodule
